// File: rtl/dmem_port_arbiter_if.sv
// Data-memory port bundle: CPU and DMA request sides plus the
// shared synchronous-read memory port.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 14
);
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [3:0]        cpu_we;
  logic [31:0]       cpu_din;
  logic              cpu_stall;
  logic              cpu_rvalid;

  logic              dma_req;
  logic [ADDR_W-1:0] dma_addr;
  logic [3:0]        dma_we;
  logic [31:0]       dma_din;
  logic              dma_gnt;
  logic              dma_rvalid;

  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic [31:0]       mem_rdata;

  modport slave (
    input  cpu_req, cpu_addr, cpu_we, cpu_din,
    input  dma_req, dma_addr, dma_we, dma_din,
    input  mem_rdata,
    output cpu_stall, cpu_rvalid,
    output dma_gnt, dma_rvalid,
    output mem_en, mem_we, mem_addr, mem_din
  );

  modport master (
    output cpu_req, cpu_addr, cpu_we, cpu_din,
    output dma_req, dma_addr, dma_we, dma_din,
    output mem_rdata,
    input  cpu_stall, cpu_rvalid,
    input  dma_gnt, dma_rvalid,
    input  mem_en, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// CPU/DMA arbiter for the data-memory port: CPU priority with
// a starvation-forced DMA burst window and read-return routing.
module dmem_port_arbiter #(
  parameter int ADDR_W    = 14,
  parameter int MAX_WAIT  = 8,
  parameter int BURST_LEN = 4
) (
  input logic                clk,
  input logic                rst,
  dmem_port_arbiter_if.slave bus
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam logic [WW-1:0] WAIT_MAX   = WW'(MAX_WAIT);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);

  typedef enum logic {
    CPU_PRI,
    DMA_BURST
  } state_t;

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic [BW-1:0] burst_cnt;
  logic          rd_cpu;
  logic          rd_dma;
  logic          cpu_grant;
  logic          dma_grant;
  logic          forced;

  // Reset gates every grant so nothing reaches memory that cycle
  always_comb begin
    forced    = 1'b0;
    cpu_grant = 1'b0;
    dma_grant = 1'b0;
    if (!rst) begin
      unique case (state)
        CPU_PRI: begin
          forced    = bus.dma_req && (wait_cnt == WAIT_MAX);
          dma_grant = bus.dma_req && (!bus.cpu_req || forced);
          cpu_grant = bus.cpu_req && !dma_grant;
        end
        DMA_BURST: begin
          dma_grant = bus.dma_req;
          cpu_grant = bus.cpu_req && !bus.dma_req;
        end
        default: ;
      endcase
    end
  end

  assign bus.cpu_stall  = bus.cpu_req && !cpu_grant && !rst;
  assign bus.dma_gnt    = dma_grant;
  assign bus.cpu_rvalid = rd_cpu && !rst;
  assign bus.dma_rvalid = rd_dma && !rst;

  always_comb begin
    bus.mem_en   = 1'b0;
    bus.mem_we   = '0;
    bus.mem_addr = '0;
    bus.mem_din  = '0;
    unique case (1'b1)
      cpu_grant: begin
        bus.mem_en   = 1'b1;
        bus.mem_we   = bus.cpu_we;
        bus.mem_addr = bus.cpu_addr;
        bus.mem_din  = bus.cpu_din;
      end
      dma_grant: begin
        bus.mem_en   = 1'b1;
        bus.mem_we   = bus.dma_we;
        bus.mem_addr = bus.dma_addr;
        bus.mem_din  = bus.dma_din;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CPU_PRI;
      wait_cnt  <= '0;
      burst_cnt <= '0;
      rd_cpu    <= 1'b0;
      rd_dma    <= 1'b0;
    end else begin
      rd_cpu <= cpu_grant && (bus.cpu_we == 4'h0);
      rd_dma <= dma_grant && (bus.dma_we == 4'h0);

      if (dma_grant)
        wait_cnt <= '0;
      else if (bus.dma_req && (wait_cnt != WAIT_MAX))
        wait_cnt <= wait_cnt + WW'(1);

      // burst_cnt counts grants already issued in the window
      unique case (state)
        CPU_PRI: begin
          if (forced && (BURST_LEN > 1)) begin
            state     <= DMA_BURST;
            burst_cnt <= BW'(1);
          end
        end
        DMA_BURST: begin
          if (!bus.dma_req || (burst_cnt == BURST_LAST)) begin
            state     <= CPU_PRI;
            burst_cnt <= '0;
          end else begin
            burst_cnt <= burst_cnt + BW'(1);
          end
        end
        default: begin
          state     <= CPU_PRI;
          burst_cnt <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter with a behavioural
// synchronous-read memory model.
module tb_dmem_port_arbiter;
  localparam int AW = 14;

  typedef struct packed {
    logic        cv;
    logic        dv;
    logic [31:0] data;
  } rv_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ADDR_W(AW)) bus ();

  dmem_port_arbiter #(
    .ADDR_W(AW),
    .MAX_WAIT(8),
    .BURST_LEN(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [31:0] mem [int];
  logic [31:0] shadow [int];
  logic [31:0] wtmp;
  rv_t exp_q [$];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] pat(int a);
    return 32'hA5000000 ^ (a * 32'h00010203);
  endfunction

  always @(posedge clk) begin
    if (bus.mem_en) begin
      wtmp = mem.exists(int'(bus.mem_addr)) ?
             mem[int'(bus.mem_addr)] : pat(int'(bus.mem_addr));
      if (bus.mem_we == 4'h0) begin
        bus.mem_rdata <= wtmp;
      end else begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_we[b]) wtmp[8*b +: 8] = bus.mem_din[8*b +: 8];
        mem[int'(bus.mem_addr)] = wtmp;
      end
    end
  end

  function automatic logic [31:0] sh_rd(int a);
    return shadow.exists(a) ? shadow[a] : pat(a);
  endfunction

  task automatic sh_wr(int a, logic [3:0] we, logic [31:0] d);
    logic [31:0] w;
    w = sh_rd(a);
    for (int b = 0; b < 4; b++)
      if (we[b]) w[8*b +: 8] = d[8*b +: 8];
    shadow[a] = w;
  endtask

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pop_rv(string tag);
    rv_t e;
    e = '0;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    check({tag, "/rv"}, 64'({bus.cpu_rvalid, bus.dma_rvalid}),
          64'({e.cv, e.dv}));
    if (e.cv || e.dv)
      check({tag, "/rdata"}, 64'(bus.mem_rdata), 64'(e.data));
  endtask

  task automatic step(string tag,
                      bit cr, int ca, logic [3:0] cwe, logic [31:0] cd,
                      bit dr, int da, logic [3:0] dwe, logic [31:0] dd,
                      bit e_stall, bit e_gnt);
    rv_t nxt;
    bit cown;
    logic [50:0] em;
    rst          = 1'b0;
    bus.cpu_req  = cr;
    bus.cpu_addr = AW'(ca);
    bus.cpu_we   = cwe;
    bus.cpu_din  = cd;
    bus.dma_req  = dr;
    bus.dma_addr = AW'(da);
    bus.dma_we   = dwe;
    bus.dma_din  = dd;
    @(negedge clk);
    check({tag, "/stall"}, 64'(bus.cpu_stall), 64'(e_stall));
    check({tag, "/gnt"}, 64'(bus.dma_gnt), 64'(e_gnt));
    cown = cr && !e_stall;
    em = '0;
    if (cown) em = {1'b1, cwe, AW'(ca), cd};
    else if (e_gnt) em = {1'b1, dwe, AW'(da), dd};
    check({tag, "/mem"},
          64'({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_din}),
          64'(em));
    pop_rv(tag);
    nxt = '0;
    if (cown) begin
      if (cwe == 4'h0) begin nxt.cv = 1'b1; nxt.data = sh_rd(ca); end
      else sh_wr(ca, cwe, cd);
    end else if (e_gnt) begin
      if (dwe == 4'h0) begin nxt.dv = 1'b1; nxt.data = sh_rd(da); end
      else sh_wr(da, dwe, dd);
    end
    exp_q.push_back(nxt);
    @(posedge clk);
    #1;
  endtask

  task automatic rst_step(string tag);
    rst          = 1'b1;
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = AW'(16'h0050);
    bus.cpu_we   = 4'h0;
    bus.cpu_din  = 32'h0;
    bus.dma_req  = 1'b1;
    bus.dma_addr = AW'(16'h0060);
    bus.dma_we   = 4'h0;
    bus.dma_din  = 32'h0;
    @(negedge clk);
    check({tag, "/outs"},
          64'({bus.cpu_stall, bus.cpu_rvalid, bus.dma_gnt,
               bus.dma_rvalid, bus.mem_en, bus.mem_we,
               bus.mem_addr, bus.mem_din}), 64'(0));
    exp_q.delete();
    exp_q.push_back('0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(string tag);
    step(tag, 0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0);
  endtask

  task automatic both(string tag, int i, bit e_stall, bit e_gnt);
    step(tag, 1, 'h100 + i, 4'h0, 0, 1, 'h200 + i, 4'h0, 0,
         e_stall, e_gnt);
  endtask

  initial begin
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;
    @(posedge clk);
    #1;
    rst_step("reset");

    for (int i = 0; i < 3; i++)
      step($sformatf("cpu_only%0d", i), 1, 'h010, 4'h0, 0,
           0, 0, 4'h0, 0, 0, 0);
    idle("cpu_only_tail");

    step("dma_wr", 0, 0, 4'h0, 0, 1, 'h020, 4'hF, 32'hDEADBEEF, 0, 1);
    idle("dma_wr_tail");
    step("dma_rd", 0, 0, 4'h0, 0, 1, 'h020, 4'h0, 0, 0, 1);
    idle("dma_rd_tail");

    step("route_dma", 0, 0, 4'h0, 0, 1, 'h030, 4'h0, 0, 0, 1);
    step("route_cpu", 1, 'h040, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0);
    idle("route_tail");

    for (int i = 0; i < 8; i++)
      both($sformatf("starve_deny%0d", i), i, 0, 0);
    for (int i = 8; i < 12; i++)
      both($sformatf("starve_burst%0d", i), i, 1, 1);
    both("starve_end", 12, 0, 0);

    for (int i = 13; i < 20; i++)
      both($sformatf("cut_deny%0d", i), i, 0, 0);
    both("cut_burst20", 20, 1, 1);
    both("cut_burst21", 21, 1, 1);
    step("cut_drop", 1, 'h150, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0);
    for (int i = 23; i < 31; i++)
      both($sformatf("cut_redeny%0d", i), i, 0, 0);
    both("cut_reburst", 31, 1, 1);

    rst_step("rst_mid");
    both("post_rst", 40, 0, 0);
    idle("post_rst_tail");
    idle("final");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
